systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream edge stage of the systolic array. It buffers one N×N A operand and one N×N B operand, then streams them into the array's west edge (A, one lane per row) and north edge (B, one lane per column).
- Each lane is time-skewed by its index, so matching A[i][k]/B[k][j] pairs meet in PE(i,j) on the same cycle.
- Zero is driven on every lane outside the valid window. Zero is the array's "no product" value.

Parameters:
N, 4, array dimension (rows = columns = inner dimension); N >= 2
DATA_WIDTH, 8, operand width, matching the PE data width
DRAIN_CYCLES, 2*N, zero cycles driven after the last operand before done; covers propagation to PE(N-1,N-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  load beat valid
in_ready  out  1  feeder accepts a load beat
a_vec  in  N*DATA_WIDTH  A row r (beat r); element k at [k*DATA_WIDTH +: DATA_WIDTH]
b_vec  in  N*DATA_WIDTH  B column r (beat r); element k at [k*DATA_WIDTH +: DATA_WIDTH]
a_edge  out  N*DATA_WIDTH  west-edge operands; lane i drives array row i
b_edge  out  N*DATA_WIDTH  north-edge operands; lane j drives array column j
busy  out  1  high in FEED and DRAIN
done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset (async, any state):
  - state=LOAD; beat, feed and drain counters = 0.
  - a_edge=0, b_edge=0, busy=0, done=0.
  - A/B buffers cleared to 0.
- States: LOAD, FEED, DRAIN.
- LOAD:
  - in_ready=1 (combinational from state only); in_ready=0 in every other state.
  - A beat is accepted on an edge with in_valid & in_ready. a_vec is written to A buffer row beat_cnt; b_vec to B buffer column beat_cnt; beat_cnt increments.
  - The edge accepting beat N-1 moves to FEED with t=0 and beat_cnt=0.
  - in_valid=0 stalls with no state change. Edge outputs hold 0.
- Skew function S(t), for t = 0..2N-2:
  - a_edge lane i = A[i][t-i] when 0 <= t-i < N, else 0.
  - b_edge lane j = B[t-j][j] when 0 <= t-j < N, else 0.
- FEED:
  - Each edge registers S(t) onto a_edge/b_edge and increments t.
  - The edge with t=2N-2 moves to DRAIN with drain_cnt=0.
  - Edge outputs carry S(0)..S(2N-2) on 2N-1 consecutive cycles, starting the cycle after the last load beat.
- DRAIN:
  - Edge outputs are registered to 0 on the first DRAIN edge and held at 0.
  - drain_cnt increments each edge.
  - The edge with drain_cnt=DRAIN_CYCLES-1 sets done=1 for exactly one cycle and returns to LOAD.
- busy is registered: 1 in the cycles spent in FEED/DRAIN, 0 otherwise.
- Latency: last load beat accepted on edge E. S(0) visible after E+1. done high in the cycle after edge E+2N-1+DRAIN_CYCLES.
- in_valid during FEED/DRAIN is ignored; no beat is accepted or lost, and the source holds it.
- Back-to-back: the next matrix may load from the cycle done is high.
- Reset mid-FEED/DRAIN: edges go to 0 immediately (async). Operation is abandoned. The array must be reset by the same signal, since PE accumulators clear only on reset.
- Zero operand values pass through unchanged. No arithmetic, no width change.

Decomposition:
- Shared package: DATA_WIDTH, N, state encoding (LOAD/FEED/DRAIN), and the lane-slice helper function (index → bit offset). These are reused by the result-drain stage.
- One sub-module, skew_lane_sel: combinational per-lane selector computing one lane of S(t) from the buffer and index. It is instantiated N times for A and N times for B.
- The FSM and all registers live in the top.

Test Plan:
- Basic feed (N=2):
  - Stimulus: beats a={1,2},b={5,7}, then a={3,4},b={6,8}.
  - Required: a_edge lanes(0,1) = (1,0),(2,3),(0,4); b_edge lanes = (5,0),(7,6),(0,8) on three consecutive cycles; then zeros.
  - Attached 2×2 MAC array after done: results 19,22,43,50.
- Handshake stall (N=2): in_valid low for 3 cycles between beats → in_ready stays 1, no state change, edges 0; feed starts the cycle after beat 1.
- Ignored input (N=4): in_valid held high during FEED/DRAIN with changing data → buffers unchanged; S(t) matches the loaded matrices.
- Timing (N=4, DRAIN_CYCLES=8): after the last beat → exactly 7 nonzero-window cycles; busy high 15 cycles; done a single pulse; in_ready=1 the same cycle as done.
- Reset mid-FEED (N=4): assert reset at t=3 → edges, busy, done 0 immediately; reload identity A, B=all-7 → array results 7 everywhere.
- Back-to-back (N=2): load the second matrix starting the cycle done is high → second feed window is correct, with no overlap with the first.

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: sizes, FSM encoding and lane slicing shared by the
// systolic array edge stages (operand feeder and result drain).
package systolic_skew_feeder_pkg;
    localparam int N          = 4;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {LOAD, FEED, DRAIN} state_t;

    function automatic int lane_off(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: load handshake from the operand source plus the
// skewed west/north edge buses and status toward the array.
interface systolic_skew_feeder_if #(
    parameter int N          = systolic_skew_feeder_pkg::N,
    parameter int DATA_WIDTH = systolic_skew_feeder_pkg::DATA_WIDTH
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] a_vec;
    logic [N*DATA_WIDTH-1:0] b_vec;
    logic [N*DATA_WIDTH-1:0] a_edge;
    logic [N*DATA_WIDTH-1:0] b_edge;
    logic                    busy;
    logic                    done;

    modport master (
        output in_valid, a_vec, b_vec,
        input  in_ready, a_edge, b_edge, busy, done
    );

    modport slave (
        input  in_valid, a_vec, b_vec,
        output in_ready, a_edge, b_edge, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder_skew_lane_sel.sv
// skew_lane_sel: one lane of the skewed edge vector; emits element t-LANE of the
// lane's operand sequence while that index is in range, zero otherwise.
module skew_lane_sel #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int LANE = 0,
    parameter int TW   = 3
) (
    input  logic [TW-1:0]   t,
    input  logic [N*DW-1:0] seq,
    output logic [DW-1:0]   lane
);
    import systolic_skew_feeder_pkg::lane_off;

    always_comb begin
        lane = '0;
        for (int k = 0; k < N; k++)
            if (int'(t) == LANE + k) lane = seq[lane_off(k, DW) +: DW];
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one N x N A/B operand pair, then streams them into
// the array edges with per-lane skew so A[i][k] meets B[k][j] in PE(i,j).
module systolic_skew_feeder #(
    parameter int N            = systolic_skew_feeder_pkg::N,
    parameter int DATA_WIDTH   = systolic_skew_feeder_pkg::DATA_WIDTH,
    parameter int DRAIN_CYCLES = 2 * N
) (
    input logic                   clk,
    input logic                   reset,
    systolic_skew_feeder_if.slave bus
);
    import systolic_skew_feeder_pkg::state_t;
    import systolic_skew_feeder_pkg::LOAD;
    import systolic_skew_feeder_pkg::FEED;
    import systolic_skew_feeder_pkg::DRAIN;
    import systolic_skew_feeder_pkg::lane_off;

    localparam int VW  = N * DATA_WIDTH;
    localparam int BW  = $clog2(N);
    localparam int TW  = $clog2(2 * N);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [TW-1:0]    t_q, t_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [VW-1:0]    a_buf_q [N];
    logic [VW-1:0]    a_buf_d [N];
    logic [VW-1:0]    b_buf_q [N];
    logic [VW-1:0]    b_buf_d [N];
    logic [VW-1:0]    a_edge_q, a_edge_d, b_edge_q, b_edge_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [VW-1:0]    a_sel, b_sel;

    // A is held row-wise and B column-wise, so each buffer entry is already one lane's sequence
    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane_sel #(.N(N), .DW(DATA_WIDTH), .LANE(g), .TW(TW)) u_a (
            .t(t_q), .seq(a_buf_q[g]), .lane(a_sel[lane_off(g, DATA_WIDTH) +: DATA_WIDTH])
        );
        skew_lane_sel #(.N(N), .DW(DATA_WIDTH), .LANE(g), .TW(TW)) u_b (
            .t(t_q), .seq(b_buf_q[g]), .lane(b_sel[lane_off(g, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    assign bus.in_ready = (state_q == LOAD);
    assign bus.a_edge   = a_edge_q;
    assign bus.b_edge   = b_edge_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        t_d      = t_q;
        drain_d  = drain_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        a_edge_d = '0;
        b_edge_d = '0;
        done_d   = 1'b0;
        case (state_q)
            LOAD: if (bus.in_valid) begin
                a_buf_d[beat_q] = bus.a_vec;
                b_buf_d[beat_q] = bus.b_vec;
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(N - 1)) begin
                    state_d = FEED;
                    beat_d  = '0;
                    t_d     = '0;
                end
            end
            FEED: begin
                a_edge_d = a_sel;
                b_edge_d = b_sel;
                t_d      = t_q + 1'b1;
                if (t_q == TW'(2 * N - 2)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = LOAD;
                    done_d  = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= LOAD;
            beat_q   <= '0;
            t_q      <= '0;
            drain_q  <= '0;
            a_edge_q <= '0;
            b_edge_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int r = 0; r < N; r++) begin
                a_buf_q[r] <= '0;
                b_buf_q[r] <= '0;
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            t_q      <= t_d;
            drain_q  <= drain_d;
            a_edge_q <= a_edge_d;
            b_edge_q <= b_edge_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_buf_q  <= a_buf_d;
            b_buf_q  <= b_buf_d;
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed checks of the skew feeder at N=2 and N=4, with a
// behavioural systolic MAC array rebuilt from the recorded edge streams.
module tb_systolic_skew_feeder;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.N(2), .DATA_WIDTH(8)) if2 ();
    systolic_skew_feeder_if #(.N(4), .DATA_WIDTH(8)) if4 ();

    systolic_skew_feeder #(.N(2), .DATA_WIDTH(8), .DRAIN_CYCLES(4)) u2 (.clk(clk), .reset(reset), .bus(if2));
    systolic_skew_feeder #(.N(4), .DATA_WIDTH(8), .DRAIN_CYCLES(8)) u4 (.clk(clk), .reset(reset), .bus(if4));

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int c0_2     = 0;
    int c0_4     = 0;
    logic [31:0] ha2 [1024];
    logic [31:0] hb2 [1024];
    logic [31:0] ha4 [1024];
    logic [31:0] hb4 [1024];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ha2[cyc & 1023] = 32'(if2.a_edge);
        hb2[cyc & 1023] = 32'(if2.b_edge);
        ha4[cyc & 1023] = if4.a_edge;
        hb4[cyc & 1023] = if4.b_edge;
    endtask

    // PE(i,j) sees west lane i delayed by j hops and north lane j delayed by i hops
    function automatic int mac(input bit big, input int c0, input int i, input int j);
        int n, s, ca, cb;
        logic [31:0] av, bv;
        n = big ? 4 : 2;
        s = 0;
        for (int c = c0; c < c0 + 3 * n; c++) begin
            ca = c - j;
            cb = c - i;
            if (ca >= c0 && cb >= c0) begin
                av = big ? ha4[ca & 1023] : ha2[ca & 1023];
                bv = big ? hb4[cb & 1023] : hb2[cb & 1023];
                s += int'(av[i*8 +: 8]) * int'(bv[j*8 +: 8]);
            end
        end
        return s;
    endfunction

    task automatic load2(input logic [31:0] av, input logic [31:0] bv, input int stall);
        for (int r = 0; r < 2; r++) begin
            if2.in_valid = 1'b1;
            if2.a_vec    = av[r*16 +: 16];
            if2.b_vec    = bv[r*16 +: 16];
            tick();
            if (r == 0) begin
                if2.in_valid = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    chk("stall_hold", {if2.in_ready, if2.busy, if2.done, if2.a_edge, if2.b_edge}, {3'b100, 32'd0});
                end
            end
        end
        if2.in_valid = 1'b0;
        c0_2 = cyc + 1;
    endtask

    task automatic load4(input logic [127:0] av, input logic [127:0] bv);
        for (int r = 0; r < 4; r++) begin
            if4.in_valid = 1'b1;
            if4.a_vec    = av[r*32 +: 32];
            if4.b_vec    = bv[r*32 +: 32];
            tick();
        end
        if4.in_valid = 1'b0;
        c0_4 = cyc + 1;
    endtask

    task automatic run_to_done(input bit big, input bit noise, output int busy_n, output int nz_n,
                               output int ticks, output bit seen);
        busy_n = 0;
        nz_n   = 0;
        ticks  = 0;
        seen   = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (big ? if4.done : if2.done) seen = 1'b1;
            else begin
                if (big ? if4.busy : if2.busy) busy_n++;
                if (big ? ((|if4.a_edge) || (|if4.b_edge)) : ((|if2.a_edge) || (|if2.b_edge))) nz_n++;
                if (noise) begin
                    if4.in_valid = 1'b1;
                    if4.a_vec    = {$urandom, $urandom, $urandom, $urandom};
                    if4.b_vec    = {$urandom, $urandom, $urandom, $urandom};
                end
                tick();
                ticks++;
            end
        end
        if (noise) if4.in_valid = 1'b0;
    endtask

    initial begin
        int bn, nz, tk, c0;
        bit seen;
        logic [127:0] a4, b4, aid, b7;
        int exp_tri [16] = '{1, 3, 6, 10, 5, 11, 18, 26, 9, 19, 30, 42, 13, 27, 42, 58};
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a4[(i*4+k)*8 +: 8]  = 8'(4 * i + k + 1);
                b4[(i*4+k)*8 +: 8]  = (k <= i) ? 8'd1 : 8'd0;
                aid[(i*4+k)*8 +: 8] = (k == i) ? 8'd1 : 8'd0;
                b7[(i*4+k)*8 +: 8]  = 8'd7;
            end
        if2.in_valid = 1'b0; if2.a_vec = '0; if2.b_vec = '0;
        if4.in_valid = 1'b0; if4.a_vec = '0; if4.b_vec = '0;
        #1 reset = 1'b1;
        #1;
        chk("reset_out2", {if2.in_ready, if2.busy, if2.done, if2.a_edge, if2.b_edge}, {3'b100, 32'd0});
        chk("reset_out4", {if4.in_ready, if4.busy, if4.done, if4.a_edge, if4.b_edge}, {3'b100, 64'd0});
        tick();
        tick();
        reset = 1'b0;
        tick();

        // basic N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        load2({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd6, 8'd7, 8'd5}, 0);
        chk("feed_entry", {if2.in_ready, if2.busy, if2.a_edge, if2.b_edge}, {2'b01, 32'd0});
        run_to_done(0, 0, bn, nz, tk, seen);
        chk("basic_done_seen", 128'(seen), 128'd1);
        chk("basic_latency", 128'(tk), 128'd7);
        chk("basic_busy", 128'(bn), 128'd7);
        chk("basic_nz", 128'(nz), 128'd3);
        chk("basic_ready_at_done", 128'(if2.in_ready), 128'd1);
        chk("basic_s0", {ha2[c0_2], hb2[c0_2]}, {32'h0001, 32'h0005});
        chk("basic_s1", {ha2[c0_2+1], hb2[c0_2+1]}, {32'h0302, 32'h0607});
        chk("basic_s2", {ha2[c0_2+2], hb2[c0_2+2]}, {32'h0400, 32'h0800});
        chk("basic_after", {ha2[c0_2+3], hb2[c0_2+3]}, 128'd0);
        chk("basic_c00", 128'(mac(0, c0_2, 0, 0)), 128'd19);
        chk("basic_c01", 128'(mac(0, c0_2, 0, 1)), 128'd22);
        chk("basic_c10", 128'(mac(0, c0_2, 1, 0)), 128'd43);
        chk("basic_c11", 128'(mac(0, c0_2, 1, 1)), 128'd50);

        // back-to-back: first beat presented in the done cycle; A=[[1,1],[2,0]], B=[[1,5],[4,6]]
        load2({8'd0, 8'd2, 8'd1, 8'd1}, {8'd6, 8'd5, 8'd4, 8'd1}, 0);
        run_to_done(0, 0, bn, nz, tk, seen);
        chk("b2b_done_seen", 128'(seen), 128'd1);
        chk("b2b_latency", 128'(tk), 128'd7);
        chk("b2b_gap", {ha2[c0_2-1], hb2[c0_2-1]}, 128'd0);
        chk("b2b_s0", {ha2[c0_2], hb2[c0_2]}, {32'h0001, 32'h0001});
        chk("b2b_s1_b", 128'(hb2[c0_2+1]), 128'h0504);
        chk("b2b_c00", 128'(mac(0, c0_2, 0, 0)), 128'd5);
        chk("b2b_c01", 128'(mac(0, c0_2, 0, 1)), 128'd11);
        chk("b2b_c10", 128'(mac(0, c0_2, 1, 0)), 128'd2);
        chk("b2b_c11", 128'(mac(0, c0_2, 1, 1)), 128'd10);
        tick();
        chk("b2b_done_pulse", 128'(if2.done), 128'd0);

        // stall of 3 cycles between beats; A=[[3,1],[0,2]], B=[[2,1],[1,3]]
        load2({8'd2, 8'd0, 8'd1, 8'd3}, {8'd3, 8'd1, 8'd1, 8'd2}, 3);
        run_to_done(0, 0, bn, nz, tk, seen);
        chk("stall_done_seen", 128'(seen), 128'd1);
        chk("stall_latency", 128'(tk), 128'd7);
        chk("stall_s0", {ha2[c0_2], hb2[c0_2]}, {32'h0003, 32'h0002});
        chk("stall_c00", 128'(mac(0, c0_2, 0, 0)), 128'd7);
        chk("stall_c01", 128'(mac(0, c0_2, 0, 1)), 128'd6);
        chk("stall_c10", 128'(mac(0, c0_2, 1, 0)), 128'd2);
        chk("stall_c11", 128'(mac(0, c0_2, 1, 1)), 128'd6);

        // N=4 timing with in_valid held high and random data during FEED/DRAIN
        load4(a4, b4);
        run_to_done(1, 1, bn, nz, tk, seen);
        chk("t4_done_seen", 128'(seen), 128'd1);
        chk("t4_latency", 128'(tk), 128'd15);
        chk("t4_busy", 128'(bn), 128'd15);
        chk("t4_nz", 128'(nz), 128'd7);
        chk("t4_ready_at_done", 128'(if4.in_ready), 128'd1);
        chk("t4_s3", {ha4[c0_4+3], hb4[c0_4+3]}, {32'h0d0a0704, 32'h01010000});
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("t4_c%0d%0d", i, j), 128'(mac(1, c0_4, i, j)), 128'(exp_tri[i*4+j]));
        tick();
        chk("t4_done_pulse", {if4.done, if4.busy, if4.in_ready}, 128'b001);

        // reset in the middle of FEED, then reload identity A with B all sevens
        load4(a4, b4);
        c0 = c0_4;
        for (int s = 0; s < 4; s++) tick();
        chk("rst_pre_s3", 128'(if4.a_edge), 128'h0d0a0704);
        #1 reset = 1'b1;
        #1;
        chk("rst_async", {if4.in_ready, if4.busy, if4.done, if4.a_edge, if4.b_edge}, {3'b100, 64'd0});
        tick();
        reset = 1'b0;
        tick();
        load4(aid, b7);
        chk("rst_restart", 128'(c0_4 > c0), 128'd1);
        run_to_done(1, 0, bn, nz, tk, seen);
        chk("rst_done_seen", 128'(seen), 128'd1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("rst_c%0d%0d", i, j), 128'(mac(1, c0_4, i, j)), 128'd7);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
